// File: rtl/panel_bus_arbiter.sv
// panel_bus_arbiter
//  Passes the shared 16-bit RAM bus between the physical 6502 and the FPGA front panel.
//  The bus is taken only while the CPU is halted and a panel request is pending. The
//  transceiver hand-off has dead time in both directions. Single-byte RAM reads/writes
//  run as SETUP -> STROBE -> RECOVER, and the bus returns to the 6502 after a linger
//  period, or as soon as the CPU is released.
//  Optional feature: define PANEL_BUS_VERIFY_EN to follow every write with a readback of
//  the same address. rsp_err then flags a readback that differs from the write data.
// Ports
//  CLK25MHZ, rst_n          clock, asynchronous active-low reset
//  cpu_stopped              CPU halted (synchronous to CLK25MHZ)
//  req_* / req_ready        panel request; accepted when req_valid & req_ready
//  rsp_valid/rdata/err      one-clock completion pulse, read data, readback error
//  bus_owned                FPGA masters the bus
//  drive_busN, cpu_bus_enN  transceiver controls (never both 0)
//  ram_csN, ram_rwN         RAM strobes
//  addr_out, data_out       bus address/write data
//  data_oe                  FPGA drives D
//  data_in                  D, already synchronised
module panel_bus_arbiter #(
   parameter int unsigned DEAD_CYCLES   = 2,
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned STROBE_CYCLES = 3,
   parameter int unsigned LINGER_CYCLES = 250
) (
   input  logic        CLK25MHZ,
   input  logic        rst_n,
   input  logic        cpu_stopped,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic        bus_owned,
   output logic        drive_busN,
   output logic        cpu_bus_enN,
   output logic        ram_csN,
   output logic        ram_rwN,
   output logic [15:0] addr_out,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;
   // The linger count never goes past LINGER_CYCLES-1 before the bus is released.
   localparam int unsigned LW = (LINGER_CYCLES > 1) ? $clog2(LINGER_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HAND_IN,
      S_OWNED,
      S_SETUP,
      S_STROBE,
      S_RECOVER,
      S_HAND_OUT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] linger_q, linger_d;
   logic          we_q, we_d;
   logic [DW-1:0] rd_q, rd_d;

   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          bus_owned_q, bus_owned_d;
   logic          drive_bus_n_q, drive_bus_n_d;
   logic          cpu_bus_en_n_q, cpu_bus_en_n_d;
   logic          ram_cs_n_q, ram_cs_n_d;
   logic          ram_rw_n_q, ram_rw_n_d;
   logic [AW-1:0] addr_out_q, addr_out_d;
   logic [DW-1:0] data_out_q, data_out_d;
   logic          data_oe_q, data_oe_d;

`ifdef PANEL_BUS_VERIFY_EN
   logic          chk_q, chk_d;
   logic          rsp_err_q, rsp_err_d;
`endif

   // State and registered outputs
   always_ff @(posedge CLK25MHZ or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         linger_q       <= '0;
         we_q           <= 1'b0;
         rd_q           <= '0;
         req_ready_q    <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         bus_owned_q    <= 1'b0;
         drive_bus_n_q  <= 1'b1;
         cpu_bus_en_n_q <= 1'b0;
         ram_cs_n_q     <= 1'b1;
         ram_rw_n_q     <= 1'b1;
         addr_out_q     <= '0;
         data_out_q     <= '0;
         data_oe_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         linger_q       <= linger_d;
         we_q           <= we_d;
         rd_q           <= rd_d;
         req_ready_q    <= req_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         bus_owned_q    <= bus_owned_d;
         drive_bus_n_q  <= drive_bus_n_d;
         cpu_bus_en_n_q <= cpu_bus_en_n_d;
         ram_cs_n_q     <= ram_cs_n_d;
         ram_rw_n_q     <= ram_rw_n_d;
         addr_out_q     <= addr_out_d;
         data_out_q     <= data_out_d;
         data_oe_q      <= data_oe_d;
      end
   end

`ifdef PANEL_BUS_VERIFY_EN
   // Readback phase flag and error flag
   always_ff @(posedge CLK25MHZ or negedge rst_n) begin
      if (!rst_n) begin
         chk_q     <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         chk_q     <= chk_d;
         rsp_err_q <= rsp_err_d;
      end
   end
`endif

   // Next-state, timers and access latches
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      linger_d   = '0;
      we_d       = we_q;
      rd_d       = rd_q;
      addr_out_d = addr_out_q;
      data_out_d = data_out_q;
`ifdef PANEL_BUS_VERIFY_EN
      chk_d      = chk_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cpu_stopped && req_valid) begin
               state_d = S_HAND_IN;
               cnt_d   = CW'(DEAD_CYCLES - 1);
            end
         end
         S_HAND_IN: begin
            if (!cpu_stopped) begin
               state_d = S_HAND_OUT;
               cnt_d   = CW'(DEAD_CYCLES - 1);
            end else if (cnt_q == '0) begin
               state_d = S_OWNED;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_OWNED: begin
            // An accept wins over a release in the same clock, so no handshake is lost.
            if (req_valid && req_ready_q) begin
               state_d    = S_SETUP;
               cnt_d      = CW'(SETUP_CYCLES - 1);
               addr_out_d = req_addr;
               data_out_d = req_wdata;
               we_d       = req_we;
`ifdef PANEL_BUS_VERIFY_EN
               chk_d      = 1'b0;
`endif
            end else if (!cpu_stopped || ((32'(linger_q) + 32'd1) >= LINGER_CYCLES)) begin
               state_d = S_HAND_OUT;
               cnt_d   = CW'(DEAD_CYCLES - 1);
            end else begin
               linger_d = linger_q + LW'(1);
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_STROBE;
               cnt_d   = CW'(STROBE_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_STROBE: begin
            if (cnt_q == '0) begin
               state_d = S_RECOVER;
               if (!we_q) begin
                  rd_d = data_in;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RECOVER: begin
            state_d = S_OWNED;
`ifdef PANEL_BUS_VERIFY_EN
            // Turn a finished write into a read of the same address.
            if (we_q) begin
               state_d = S_SETUP;
               cnt_d   = CW'(SETUP_CYCLES - 1);
               we_d    = 1'b0;
               chk_d   = 1'b1;
            end
`endif
         end
         S_HAND_OUT: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs follow the state being entered
   always_comb begin
      req_ready_d    = 1'b0;
      drive_bus_n_d  = 1'b1;
      cpu_bus_en_n_d = 1'b1;
      bus_owned_d    = 1'b0;
      ram_cs_n_d     = 1'b1;
      ram_rw_n_d     = 1'b1;
      data_oe_d      = 1'b0;
      // Completion is signalled as RECOVER hands back to OWNED.
      rsp_valid_d    = (state_q == S_RECOVER) && (state_d == S_OWNED);
      rsp_rdata_d    = rsp_rdata_q;
      if (rsp_valid_d && !we_q) begin
         rsp_rdata_d = rd_q;
      end
`ifdef PANEL_BUS_VERIFY_EN
      rsp_err_d = rsp_err_q;
      if (rsp_valid_d) begin
         rsp_err_d = chk_q && (rd_q != data_out_q);
      end
`endif
      case (state_d)
         S_IDLE: cpu_bus_en_n_d = 1'b0;
         S_OWNED: begin
            drive_bus_n_d = 1'b0;
            bus_owned_d   = 1'b1;
            req_ready_d   = cpu_stopped;
         end
         S_SETUP: begin
            drive_bus_n_d = 1'b0;
            bus_owned_d   = 1'b1;
            data_oe_d     = we_d;
         end
         S_STROBE: begin
            drive_bus_n_d = 1'b0;
            bus_owned_d   = 1'b1;
            ram_cs_n_d    = 1'b0;
            ram_rw_n_d    = !we_d;
            data_oe_d     = we_d;
         end
         S_RECOVER: begin
            drive_bus_n_d = 1'b0;
            bus_owned_d   = 1'b1;
         end
         default: ;
      endcase
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign bus_owned   = bus_owned_q;
   assign drive_busN  = drive_bus_n_q;
   assign cpu_bus_enN = cpu_bus_en_n_q;
   assign ram_csN     = ram_cs_n_q;
   assign ram_rwN     = ram_rw_n_q;
   assign addr_out    = addr_out_q;
   assign data_out    = data_out_q;
   assign data_oe     = data_oe_q;
`ifdef PANEL_BUS_VERIFY_EN
   assign rsp_err     = rsp_err_q;
`else
   assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_panel_bus_arbiter.sv
`timescale 1ns/1ps
// Bench for panel_bus_arbiter: RAM model on the bus, table of directed accesses,
// hand-written sequences for hand-off, linger, CPU release and reset corner cases.
module tb_panel_bus_arbiter;

`ifdef PANEL_BUS_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int LAT_RD = 5;
   localparam int LAT_WR = VERIFY ? 10 : 5;

   logic        CLK25MHZ = 1'b0;
   logic        rst_n = 1'b1;
   logic        cpu_stopped = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err, bus_owned;
   logic        drive_busN, cpu_bus_enN, ram_csN, ram_rwN, data_oe;
   logic [7:0]  rsp_rdata, data_out, data_in;
   logic [15:0] addr_out;

   logic [7:0]  mem [0:65535];
   logic        ram_loaded = 1'b0;
   logic [7:0]  stuck_mask = 8'hFF;

   int errors = 0;
   int checks = 0;
   int overlap_bad = 0;
   int rw_bad = 0;
   int hand_ins = 0;
   logic prev_en_n = 1'b0;

   always #20 CLK25MHZ = ~CLK25MHZ;

   panel_bus_arbiter dut (
      .CLK25MHZ   (CLK25MHZ),
      .rst_n      (rst_n),
      .cpu_stopped(cpu_stopped),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .bus_owned  (bus_owned),
      .drive_busN (drive_busN),
      .cpu_bus_enN(cpu_bus_enN),
      .ram_csN    (ram_csN),
      .ram_rwN    (ram_rwN),
      .addr_out   (addr_out),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .data_in    (data_in)
   );

   // RAM model: asynchronous read while selected, write on a clock with cs and rw low.
   assign data_in = (!ram_csN && ram_rwN) ? mem[addr_out] : 8'h00;

   always @(posedge CLK25MHZ) begin
      if (!ram_loaded) begin
         mem[16'h1234] = 8'hA5;
         mem[16'hFFFF] = 8'h5A;
         ram_loaded = 1'b1;
      end else if (!ram_csN && !ram_rwN) begin
         mem[addr_out] = data_out & stuck_mask;
      end
   end

   // Bus-level monitors
   always @(negedge CLK25MHZ) begin
      if (rst_n) begin
         if (!drive_busN && !cpu_bus_enN) overlap_bad++;
         if (!ram_rwN && ram_csN) rw_bad++;
         if (cpu_bus_enN && !prev_en_n) hand_ins++;
      end
      prev_en_n = cpu_bus_enN;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One access; returns response data, accept latency and dead clocks seen before ownership.
   task automatic do_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata, output logic err,
                            output int lat, output int dead, output bit ok);
      int w;
      req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      dead = 0; w = 0;
      while (!req_ready && w < 400) begin
         @(negedge CLK25MHZ);
         w++;
         if (cpu_bus_enN && drive_busN) dead++;
      end
      ok = (w < 400);
      @(negedge CLK25MHZ);
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 60) begin
         @(negedge CLK25MHZ);
         lat++;
      end
      rdata = rsp_rdata;
      err = rsp_err;
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rdata;
      int          exp_dead;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [7:0] rd;
      logic       er;
      int         lat, dead, k, w;
      bit         ok, bad;
      logic [7:0] last_rsp;
      logic [7:0] exp_rd;
      logic [2:0] trace_exp [6];

      vecs[0] = '{we: 1'b0, addr: 16'h1234, wdata: 8'h00, exp_rdata: 8'hA5, exp_dead: 2};
      vecs[1] = '{we: 1'b1, addr: 16'hFE00, wdata: 8'h3C, exp_rdata: 8'h3C, exp_dead: 0};
      vecs[2] = '{we: 1'b0, addr: 16'hFE00, wdata: 8'h00, exp_rdata: 8'h3C, exp_dead: 0};
      vecs[3] = '{we: 1'b1, addr: 16'h0000, wdata: 8'hFF, exp_rdata: 8'hFF, exp_dead: 0};
      vecs[4] = '{we: 1'b0, addr: 16'h0000, wdata: 8'h00, exp_rdata: 8'hFF, exp_dead: 0};
      vecs[5] = '{we: 1'b0, addr: 16'hFFFF, wdata: 8'h00, exp_rdata: 8'h5A, exp_dead: 0};

      // {data_oe, ram_csN, ram_rwN} from SETUP through the first clock after RECOVER
      trace_exp[0] = 3'b111;
      trace_exp[1] = 3'b100;
      trace_exp[2] = 3'b100;
      trace_exp[3] = 3'b100;
      trace_exp[4] = 3'b011;
      trace_exp[5] = 3'b011;

      // Reset values
      #5 rst_n = 1'b0;
      #1;
      check("reset_ctl", {drive_busN, cpu_bus_enN, ram_csN, ram_rwN, data_oe, req_ready,
                          rsp_valid, rsp_err, bus_owned}, 9'b1_0_1_1_0_0_0_0_0);
      check("reset_addr", addr_out, 16'h0000);
      check("reset_data", {data_out, rsp_rdata}, 16'h0000);
      repeat (2) @(negedge CLK25MHZ);
      rst_n = 1'b1;
      @(negedge CLK25MHZ);

      // Request while the CPU runs: bus must never be taken
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234;
      bad = 1'b0;
      repeat (30) begin
         @(negedge CLK25MHZ);
         if (req_ready || cpu_bus_enN) bad = 1'b1;
      end
      check("cpu_running_no_grant", 32'(bad), 32'd0);
      req_valid = 1'b0;
      cpu_stopped = 1'b1;
      @(negedge CLK25MHZ);

      // Table of accesses while the CPU is halted
      last_rsp = 8'h00;
      for (int i = 0; i < 6; i++) begin
         do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat, dead, ok);
         check($sformatf("vec%0d_accepted", i), 32'(ok), 32'd1);
         check($sformatf("vec%0d_dead", i), dead, vecs[i].exp_dead);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].we ? LAT_WR : LAT_RD);
         exp_rd = (vecs[i].we && !VERIFY) ? last_rsp : vecs[i].exp_rdata;
         check($sformatf("vec%0d_rdata", i), rd, exp_rd);
         check($sformatf("vec%0d_err", i), er, 1'b0);
         last_rsp = exp_rd;
         if (vecs[i].we) check($sformatf("vec%0d_ram", i), mem[vecs[i].addr], vecs[i].wdata);
      end
      check("single_hand_in", hand_ins, 1);

      // Write strobe trace
      req_we = 1'b1; req_addr = 16'h0042; req_wdata = 8'h99; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin @(negedge CLK25MHZ); w++; end
      @(negedge CLK25MHZ);
      req_valid = 1'b0;
      for (int t = 0; t < 6; t++) begin
         check($sformatf("wr_trace%0d", t), {data_oe, ram_csN, ram_rwN}, trace_exp[t]);
         if (t == 1) check("wr_addr_data", {addr_out, data_out}, {16'h0042, 8'h99});
         if (t < 5) @(negedge CLK25MHZ);
      end
      w = 0;
      while (!rsp_valid && w < 20) begin @(negedge CLK25MHZ); w++; end
      check("wr_trace_rsp", 32'(rsp_valid), 32'd1);
      check("wr_trace_ram", mem[16'h0042], 8'h99);

      // Two back-to-back reads then idle until the linger release
      do_access(1'b0, 16'h1234, 8'h00, rd, er, lat, dead, ok);
      check("b2b_rd1", {rd, 8'(dead)}, {8'hA5, 8'd0});
      do_access(1'b0, 16'h0042, 8'h00, rd, er, lat, dead, ok);
      check("b2b_rd2", {rd, 8'(dead)}, {8'h99, 8'd0});
      k = 0;
      while (!drive_busN && k < 400) begin @(negedge CLK25MHZ); k++; end
      check("linger_release_clk", k, 250);
      check("release_not_owned", 32'(bus_owned), 32'd0);
      k = 0;
      while (cpu_bus_enN && k < 50) begin k++; @(negedge CLK25MHZ); end
      check("hand_out_dead", k, 2);
      check("hand_ins_after_linger", hand_ins, 1);

      // CPU released mid-access: access completes, then the bus is returned
      req_we = 1'b0; req_addr = 16'h1234; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin @(negedge CLK25MHZ); w++; end
      @(negedge CLK25MHZ);
      req_valid = 1'b0;
      cpu_stopped = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 60) begin @(negedge CLK25MHZ); lat++; end
      check("midacc_latency", lat, LAT_RD);
      check("midacc_rdata", rsp_rdata, 8'hA5);
      check("midacc_no_ready", 32'(req_ready), 32'd0);
      @(negedge CLK25MHZ);
      check("midacc_release", {drive_busN, bus_owned, cpu_bus_enN}, 3'b101);
      repeat (2) @(negedge CLK25MHZ);
      check("midacc_cpu_back", 32'(cpu_bus_enN), 32'd0);

      // CPU released during the hand-in: FPGA never drives
      cpu_stopped = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234;
      @(negedge CLK25MHZ);
      check("abort_hand_in_started", {cpu_bus_enN, drive_busN}, 2'b11);
      cpu_stopped = 1'b0; req_valid = 1'b0;
      bad = 1'b0;
      repeat (3) begin
         @(negedge CLK25MHZ);
         if (!drive_busN || req_ready || bus_owned) bad = 1'b1;
      end
      check("abort_never_owned", 32'(bad), 32'd0);
      check("abort_cpu_back", 32'(cpu_bus_enN), 32'd0);
      cpu_stopped = 1'b1;

`ifdef PANEL_BUS_VERIFY_EN
      // Readback with data bit 0 stuck low
      stuck_mask = 8'hFE;
      do_access(1'b1, 16'h0100, 8'h01, rd, er, lat, dead, ok);
      check("verify_bad_err", 32'(er), 32'd1);
      check("verify_bad_rdata", rd, 8'h00);
      check("verify_bad_latency", lat, 10);
      stuck_mask = 8'hFF;
      do_access(1'b1, 16'h0101, 8'hA5, rd, er, lat, dead, ok);
      check("verify_good", {7'd0, er, rd}, {8'h00, 8'hA5});
`endif

      // Asynchronous reset in the middle of a strobe
      req_we = 1'b1; req_addr = 16'h2000; req_wdata = 8'h77; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin @(negedge CLK25MHZ); w++; end
      @(negedge CLK25MHZ);
      req_valid = 1'b0;
      @(negedge CLK25MHZ);
      check("rst_pre_strobe", 32'(ram_csN), 32'd0);
      #5 rst_n = 1'b0;
      #1;
      check("rst_mid_strobe_ctl", {ram_csN, drive_busN, cpu_bus_enN, bus_owned, data_oe, ram_rwN},
            6'b1_1_0_0_0_1);
      check("rst_mid_strobe_data", {addr_out, data_out, rsp_rdata}, 32'h0);
      @(negedge CLK25MHZ);
      rst_n = 1'b1;
      repeat (3) @(negedge CLK25MHZ);
      check("post_reset_idle", {cpu_bus_enN, drive_busN, req_ready}, 3'b010);

      check("no_driver_overlap", overlap_bad, 0);
      check("rw_only_with_cs", rw_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
